// File: rtl/led_chaser.sv
// Parametrised dual-rate LED chaser: prescaler-driven enable ticks feed two
// pattern channels rendered as dual rotate, bounce, fill bar or freeze.
module led_chaser #(
   parameter int WIDTH  = 16,
   parameter int BAR_W  = 3,
   parameter int FAST_W = 23,
   parameter int SLOW_W = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             speed,
   input  logic [1:0]       mode,
   input  logic             restart,
   output logic [WIDTH-1:0] led,
   output logic             cycle_done
);

   localparam int PW = $clog2(WIDTH);
   localparam int LW = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] A_INIT  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] B_INIT  = {{(WIDTH-BAR_W){1'b0}}, {BAR_W{1'b1}}};
   localparam logic [PW-1:0]    POS_MAX = PW'(WIDTH - 1);
   localparam logic [LW-1:0]    LVL_MAX = LW'(WIDTH);

   typedef enum logic [1:0] {
      MODE_DUAL   = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_FILL   = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   logic [SLOW_W-1:0] presc, presc_n;
   logic [WIDTH-1:0]  a, a_n;
   logic [WIDTH-1:0]  b, b_n;
   logic [PW-1:0]     pos, pos_n;
   dir_t              dir, dir_n;
   logic [LW-1:0]     level, level_n;
   mode_t             mode_q, mode_n;
   logic              done_n;

   logic fast_tick, slow_tick, tick_a, tick_b;

   assign fast_tick = &presc[FAST_W-1:0];
   assign slow_tick = &presc;
   assign tick_a    = speed ? slow_tick : fast_tick;
   assign tick_b    = speed ? fast_tick : slow_tick;

   // Restart beats a mode change, which beats any tick landing in the same clk.
   always_comb begin
      // NOTE: every next-state value defaults to "hold" before any branch, so
      // no path leaves a variable unassigned and no latch is inferred.
      presc_n = presc + 1'b1;
      a_n     = a;
      b_n     = b;
      pos_n   = pos;
      dir_n   = dir;
      level_n = level;
      mode_n  = mode_q;
      done_n  = 1'b0;

      if (restart || (mode != mode_q)) begin
         if (restart)
            presc_n = '0;
         mode_n  = mode_t'(mode);
         a_n     = A_INIT;
         b_n     = B_INIT;
         pos_n   = POS_MAX;
         dir_n   = DIR_DOWN;
         level_n = '0;
      end else if (en) begin
         case (mode_q)
            MODE_DUAL: begin
               if (tick_a) begin
                  a_n    = {a[0], a[WIDTH-1:1]};
                  done_n = a[0];
               end
               if (tick_b)
                  b_n = {b[WIDTH-2:0], b[WIDTH-1]};
            end
            MODE_BOUNCE: begin
               if (tick_a) begin
                  // The end-stop turnaround and the step happen in one tick,
                  // so neither end position is shown twice.
                  if (dir == DIR_DOWN) begin
                     if (pos == '0) begin
                        pos_n = PW'(1);
                        dir_n = DIR_UP;
                     end else begin
                        pos_n = pos - 1'b1;
                     end
                  end else begin
                     if (pos == POS_MAX) begin
                        pos_n = POS_MAX - 1'b1;
                        dir_n = DIR_DOWN;
                     end else begin
                        pos_n = pos + 1'b1;
                     end
                  end
                  done_n = (pos_n == POS_MAX);
               end
            end
            MODE_FILL: begin
               if (tick_a) begin
                  if (level == LVL_MAX) begin
                     level_n = '0;
                     done_n  = 1'b1;
                  end else begin
                     level_n = level + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         a          <= A_INIT;
         b          <= B_INIT;
         pos        <= POS_MAX;
         dir        <= DIR_DOWN;
         level      <= '0;
         mode_q     <= MODE_DUAL;
         cycle_done <= 1'b0;
      end else begin
         presc      <= presc_n;
         a          <= a_n;
         b          <= b_n;
         pos        <= pos_n;
         dir        <= dir_n;
         level      <= level_n;
         mode_q     <= mode_n;
         cycle_done <= done_n;
      end
   end

   always_comb begin
      led = a | b;
      case (mode_q)
         MODE_BOUNCE: begin
            led      = '0;
            led[pos] = 1'b1;
         end
         MODE_FILL: begin
            for (int i = 0; i < WIDTH; i++)
               led[i] = (level > LW'(i));
         end
         default: led = a | b;
      endcase
   end

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser with short prescaler periods (fast tick every
// 4 clks, slow every 16); expected LED values are hand-computed.
module tb_led_chaser;

   localparam int WIDTH  = 8;
   localparam int BAR_W  = 3;
   localparam int FAST_W = 2;
   localparam int SLOW_W = 4;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             en      = 1'b0;
   logic             speed   = 1'b0;
   logic [1:0]       mode    = 2'b00;
   logic             restart = 1'b0;
   logic [WIDTH-1:0] led;
   logic             cycle_done;

   int n_asserts = 0;
   int n_fails   = 0;

   logic [7:0] bounce_exp [14] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                   8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [7:0] fill_exp   [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                   8'hFF, 8'h00};

   led_chaser #(
      .WIDTH  (WIDTH),
      .BAR_W  (BAR_W),
      .FAST_W (FAST_W),
      .SLOW_W (SLOW_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .speed      (speed),
      .mode       (mode),
      .restart    (restart),
      .led        (led),
      .cycle_done (cycle_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_restart(input logic [1:0] m);
      mode    = m;
      restart = 1'b1;
      step(1);
      restart = 1'b0;
   endtask

   initial begin
      int pulses;

      // Reset and DUAL timing
      en = 1'b1; speed = 1'b0; mode = 2'b00;
      #12;
      check("reset_led", led, 32'h87);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(4);
      check("pre_reset_led", led, 32'h47);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_led", led, 32'h87);
      check("async_reset_done", cycle_done, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(3);
      check("dual_t3", led, 32'h87);
      step(1);
      check("dual_t4", led, 32'h47);
      step(11);
      check("dual_t15", led, 32'h17);
      step(1);
      check("dual_t16", led, 32'h0E);
      step(15);
      check("dual_t31_done", cycle_done, 32'h0);
      step(1);
      check("dual_t32_done", cycle_done, 32'h1);
      check("dual_t32_led", led, 32'h9C);
      step(1);
      check("dual_t33_done", cycle_done, 32'h0);
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         step(1);
         if (cycle_done) pulses++;
      end
      check("dual_pulses_64clk", pulses, 32'd2);

      // Speed swap from reset
      #2;
      rst_n = 1'b0;
      speed = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(3);
      check("swap_t3", led, 32'h87);
      step(1);
      check("swap_t4", led, 32'h8E);
      step(11);
      check("swap_t15", led, 32'hB8);
      step(1);
      check("swap_t16", led, 32'h70);
      speed = 1'b0;

      // BOUNCE
      do_restart(2'b01);
      check("bounce_start", led, 32'h80);
      for (int k = 0; k < 14; k++) begin
         step(4);
         check($sformatf("bounce_led_%0d", k + 1), led, bounce_exp[k]);
         check($sformatf("bounce_done_%0d", k + 1), cycle_done, (k == 13) ? 32'h1 : 32'h0);
      end

      // FILL
      do_restart(2'b10);
      check("fill_start", led, 32'h00);
      for (int k = 0; k < 9; k++) begin
         step(4);
         check($sformatf("fill_led_%0d", k + 1), led, fill_exp[k]);
         check($sformatf("fill_done_%0d", k + 1), cycle_done, (k == 8) ? 32'h1 : 32'h0);
      end

      // Hold with en=0, then FREEZE
      do_restart(2'b00);
      step(8);
      check("hold_before", led, 32'h27);
      en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         check("hold_led", led, 32'h27);
         check("hold_done", cycle_done, 32'h0);
      end
      en   = 1'b1;
      mode = 2'b11;
      step(1);
      check("freeze_reload", led, 32'h87);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("freeze_led", led, 32'h87);
         check("freeze_done", cycle_done, 32'h0);
      end

      // Restart colliding with a fast tick
      do_restart(2'b00);
      step(3);
      check("rst_coll_pre", led, 32'h87);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      check("rst_coll_led", led, 32'h87);
      check("rst_coll_done", cycle_done, 32'h0);
      step(3);
      check("rst_coll_presc_clear", led, 32'h87);
      step(1);
      check("rst_coll_first_tick", led, 32'h47);

      // Mode change colliding with a fast tick
      step(3);
      check("mode_coll_pre", led, 32'h47);
      mode = 2'b01;
      step(1);
      check("mode_coll_led", led, 32'h80);
      check("mode_coll_done", cycle_done, 32'h0);
      step(3);
      check("mode_coll_hold", led, 32'h80);
      step(1);
      check("mode_coll_next_tick", led, 32'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
